eth_rx_ddr_wr: RTL and testbench
================================

Name: eth_rx_ddr_wr

Overview:
Store-and-forward bridge between the eth_wrap receive AXI-Stream and the ddr_wrap write command/data interface. It buffers one complete received frame in on-chip RAM and measures its byte length. It then issues one DDR write burst per frame into a circular region of DDR. It sits downstream of eth_wrap rx_axis_* and upstream of ddr_wrap wstart/wready/waddr/wdata_len/wdata_vld/wdata, in the coreclk domain; any CDC is external.

Parameters:
DATA_WIDTH, 64, AXIS and DDR write data width in bits (multiple of 8)
ADDR_WIDTH, 32, DDR byte address width
LEN_WIDTH, 16, byte length width of wdata_len
BUF_DEPTH, 256, frame buffer depth in beats (power of 2); this is the maximum frame length
BASE_ADDR, 32'h0000_0000, ring start byte address (aligned to DATA_WIDTH/8)
RING_SIZE, 32'h0010_0000, ring size in bytes (multiple of BUF_DEPTH*DATA_WIDTH/8)

Ports:
clk  in  1  coreclk
rst  in  1  synchronous reset, active-high
rx_axis_tdata  in  DATA_WIDTH  receive data
rx_axis_tkeep  in  DATA_WIDTH/8  byte enables: contiguous from LSB, all-ones except on the tlast beat
rx_axis_tvalid  in  1  beat valid
rx_axis_tlast  in  1  last beat of frame
rx_axis_tready  out  1  beat accepted when tvalid&tready
wstart  out  1  one-cycle write command pulse
wready  in  1  ddr_wrap idle, can take wstart
waddr  out  ADDR_WIDTH  burst byte address, held stable from wstart until the next wstart
wdata_len  out  LEN_WIDTH  burst length in bytes, held like waddr
wdata_vld  out  1  write data beat valid; no back-pressure
wdata  out  DATA_WIDTH  write data
frame_cnt  out  32  frames written to DDR
drop_cnt  out  32  frames discarded
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Decided interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: rx_axis_tready=0, wstart=0, wdata_vld=0, wdata=0, waddr=BASE_ADDR, wdata_len=0, frame_cnt=0, drop_cnt=0, busy=0. Internal write pointer=BASE_ADDR.
- rst mid-operation discards the in-flight frame and returns to IDLE next cycle. No partial burst continues.
- FSM states: IDLE, RECV, DROP, CMD, DATA.
- IDLE: tready=1.
  - On an accepted beat, write it to buffer[0] and set beats=1.
  - If the beat has tlast, go to CMD; otherwise go to RECV.
- RECV: tready=1.
  - Each accepted beat writes buffer[beats] and increments beats.
  - A non-last beat arriving when beats==BUF_DEPTH goes to DROP; that beat is discarded.
  - tlast goes to CMD.
- Byte count: bytes = (beats-1)*DATA_WIDTH/8 + popcount(tkeep of last beat).
  - bytes==0 (last tkeep all-zero on a single-beat frame): drop_cnt++, return to IDLE, no burst.
- DROP: tready=1; discard beats until tlast inclusive, then drop_cnt++ and go to IDLE.
- CMD: tready=0.
  - Wrap check: if ptr + beats*DATA_WIDTH/8 > BASE_ADDR+RING_SIZE, set ptr=BASE_ADDR first. Frames are never split.
  - When wready=1, pulse wstart for 1 cycle with waddr=ptr and wdata_len=bytes, then go to DATA.
- DATA: tready=0.
  - Read buffer beats 0..beats-1 sequentially. The RAM has a registered read.
  - wdata_vld is high for exactly beats consecutive cycles, starting 2 cycles after the wstart cycle.
  - wdata carries buffer content verbatim, including the last beat's unused bytes.
  - After the final beat: ptr += beats*DATA_WIDTH/8, frame_cnt++, go to IDLE.
- Length arithmetic is done in ADDR_WIDTH bits. Counters wrap at 2^32.
- Frames arriving during CMD/DATA are back-pressured; none are lost.
- wstart is only asserted in a cycle where wready=1. wready dropping after wstart has no effect on DATA.

Optional Feature:
RX_HDR_EN
- Defined: each burst is prefixed with one header beat.
  - Header: bits[15:0]=frame byte count, bits[31:16]=16-bit sequence number (reset 0, +1 per written frame), remaining bits zero.
  - wdata_len = bytes + DATA_WIDTH/8.
  - wdata_vld lasts beats+1 cycles, header first.
  - Ring advance and wrap check use beats+1.
  - Max payload is unchanged at BUF_DEPTH beats.
- Undefined: no header; payload only, as described above.

Test Plan:
- Single 64-byte frame (8 beats, tkeep=8'hFF, incrementing data) -> wstart once; waddr=0x0, wdata_len=64; 8 consecutive wdata_vld matching input; frame_cnt=1.
- 3-beat frame with last tkeep=8'h07 (19 bytes), then a second 1-beat frame -> first burst waddr=0x0, len=19; second burst waddr=0x18, len=8 (tkeep=8'hFF).
- wready held low 50 cycles after a frame completes -> wstart waits; rx_axis_tready=0 throughout CMD; a second frame is stalled, then written intact after.
- Frame of BUF_DEPTH+1 beats -> no wstart; drop_cnt=1; next normal frame written at the unchanged ptr.
- RING_SIZE=4096, ptr=4032, next frame 16 beats (128 B) -> burst at BASE_ADDR; ptr becomes BASE_ADDR+128.
- rst asserted during DATA beat 3 of 8 -> wdata_vld=0 next cycle; all outputs at reset values; the next frame is written at BASE_ADDR with frame_cnt=1.

Source files
------------

// File: rtl/eth_rx_ddr_wr.sv
// Store-and-forward bridge: buffers one AXI-Stream frame, then writes it to a DDR ring as one burst.
// Define RX_HDR_EN to prefix each burst with a header beat {seq[15:0], bytes[15:0]}.
module eth_rx_ddr_wr #(
    parameter int                    DATA_WIDTH = 64,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    LEN_WIDTH  = 16,
    parameter int                    BUF_DEPTH  = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] RING_SIZE  = 32'h0010_0000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   rx_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] rx_axis_tkeep,
    input  logic                    rx_axis_tvalid,
    input  logic                    rx_axis_tlast,
    output logic                    rx_axis_tready,
    output logic                    wstart,
    input  logic                    wready,
    output logic [ADDR_WIDTH-1:0]   waddr,
    output logic [LEN_WIDTH-1:0]    wdata_len,
    output logic                    wdata_vld,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [31:0]             frame_cnt,
    output logic [31:0]             drop_cnt,
    output logic                    busy
);

    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int IDX_W  = $clog2(BUF_DEPTH);
    localparam int BEAT_W = IDX_W + 1;
`ifdef RX_HDR_EN
    localparam int HDR_BEATS = 1;
`else
    localparam int HDR_BEATS = 0;
`endif
    localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(KEEP_W);
    localparam logic [ADDR_WIDTH-1:0] RING_END   = BASE_ADDR + RING_SIZE;
    localparam logic [ADDR_WIDTH-1:0] HDR_BYTES  = ADDR_WIDTH'(HDR_BEATS) * BEAT_BYTES;
    localparam logic [BEAT_W-1:0]     FULL_BEATS = BEAT_W'(BUF_DEPTH);
    localparam logic [BEAT_W-1:0]     HDR_B      = BEAT_W'(HDR_BEATS);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RECV = 3'd1;
    localparam logic [2:0] S_DROP = 3'd2;
    localparam logic [2:0] S_CMD  = 3'd3;
    localparam logic [2:0] S_DATA = 3'd4;

    logic [2:0]            state, state_nxt;
    logic [BEAT_W-1:0]     beats, beats_nxt, total_beats, rd_cnt;
    logic [ADDR_WIDTH-1:0] ptr, keep_bytes, frame_bytes, new_adv, cur_adv, start_addr;
    logic                  accept, buf_full, wr_en, enter_cmd, drop_frame, last_issue;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0] buf_mem [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;

    assign accept      = rx_axis_tvalid && rx_axis_tready;
    assign buf_full    = (state == S_RECV) && (beats == FULL_BEATS);
    assign beats_nxt   = (state == S_IDLE) ? BEAT_W'(1) : beats + BEAT_W'(1);
    assign wr_idx      = (state == S_IDLE) ? '0 : beats[IDX_W-1:0];
    assign wr_en       = accept && ((state == S_IDLE) || (state == S_RECV)) && !buf_full;
    assign total_beats = beats + HDR_B;
    assign rd_idx      = IDX_W'(rd_cnt - HDR_B);
    assign last_issue  = (state == S_DATA) && (rd_cnt == total_beats - BEAT_W'(1));

    always_comb begin
        keep_bytes = '0;
        for (int i = 0; i < KEEP_W; i++)
            keep_bytes = keep_bytes + ADDR_WIDTH'(rx_axis_tkeep[i]);
    end

    // Beats already stored are full; only the beat carrying tlast contributes a partial count.
    assign frame_bytes = ((state == S_IDLE) ? '0 : ADDR_WIDTH'(beats)) * BEAT_BYTES + keep_bytes;
    assign new_adv     = ADDR_WIDTH'(beats_nxt + HDR_B) * BEAT_BYTES;
    assign cur_adv     = ADDR_WIDTH'(total_beats) * BEAT_BYTES;
    assign start_addr  = (ptr + new_adv > RING_END) ? BASE_ADDR : ptr;

    always_comb begin
        state_nxt  = state;
        drop_frame = 1'b0;
        case (state)
            S_IDLE, S_RECV: begin
                if (accept) begin
                    if (buf_full) begin
                        if (rx_axis_tlast) begin
                            state_nxt  = S_IDLE;
                            drop_frame = 1'b1;
                        end else begin
                            state_nxt = S_DROP;
                        end
                    end else if (rx_axis_tlast) begin
                        if (frame_bytes == '0) begin
                            state_nxt  = S_IDLE;
                            drop_frame = 1'b1;
                        end else begin
                            state_nxt = S_CMD;
                        end
                    end else begin
                        state_nxt = S_RECV;
                    end
                end
            end
            S_DROP: begin
                if (accept && rx_axis_tlast) begin
                    state_nxt  = S_IDLE;
                    drop_frame = 1'b1;
                end
            end
            S_CMD:   if (wready) state_nxt = S_DATA;
            S_DATA:  if (last_issue) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign enter_cmd = (state != S_CMD) && (state_nxt == S_CMD);
    assign wstart    = (state == S_CMD) && wready;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            rx_axis_tready <= 1'b0;
            wdata_vld      <= 1'b0;
            beats          <= '0;
            rd_cnt         <= '0;
            ptr            <= BASE_ADDR;
            waddr          <= BASE_ADDR;
            wdata_len      <= '0;
            frame_cnt      <= '0;
            drop_cnt       <= '0;
        end else begin
            state          <= state_nxt;
            rx_axis_tready <= (state_nxt == S_IDLE) || (state_nxt == S_RECV) || (state_nxt == S_DROP);
            wdata_vld      <= (state == S_DATA);
            if (wr_en)
                beats <= beats_nxt;
            if (drop_frame)
                drop_cnt <= drop_cnt + 32'd1;
            // Wrap is resolved on CMD entry so waddr is already final when wstart fires.
            if (enter_cmd) begin
                ptr       <= start_addr;
                waddr     <= start_addr;
                wdata_len <= LEN_WIDTH'(frame_bytes + HDR_BYTES);
            end
            if (state == S_DATA) begin
                rd_cnt <= rd_cnt + BEAT_W'(1);
                if (last_issue) begin
                    ptr       <= ptr + cur_adv;
                    frame_cnt <= frame_cnt + 32'd1;
                end
            end else begin
                rd_cnt <= '0;
            end
        end
    end

    // NOTE: the buffer array is deliberately left without reset so it maps onto block RAM;
    // only the registered read port is cleared.
    always_ff @(posedge clk) begin
        if (wr_en)
            buf_mem[wr_idx] <= rx_axis_tdata;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rd_q <= '0;
        else
            rd_q <= buf_mem[rd_idx];
    end

`ifdef RX_HDR_EN
    logic [15:0] seq;
    logic [15:0] hdr_bytes;
    logic        hdr_phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            seq       <= '0;
            hdr_bytes <= '0;
            hdr_phase <= 1'b0;
        end else begin
            hdr_phase <= (state == S_DATA) && (rd_cnt == '0);
            if (enter_cmd)
                hdr_bytes <= frame_bytes[15:0];
            if (last_issue)
                seq <= seq + 16'd1;
        end
    end

    always_comb begin
        wdata = rd_q;
        if (hdr_phase) begin
            wdata        = '0;
            wdata[15:0]  = hdr_bytes;
            wdata[31:16] = seq;
        end
    end
`else
    assign wdata = rd_q;
`endif

endmodule

// File: tb/tb_eth_rx_ddr_wr.sv
// Scoreboard bench for eth_rx_ddr_wr: a ring/pointer model predicts each burst command and data beat.
module tb_eth_rx_ddr_wr;

    localparam int          DW        = 64;
    localparam int          BUF_DEPTH = 256;
    localparam logic [31:0] BASE      = 32'h0000_0000;
    localparam logic [31:0] RING      = 32'h0000_1000;
`ifdef RX_HDR_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] rx_axis_tdata;
    logic [7:0]    rx_axis_tkeep;
    logic          rx_axis_tvalid;
    logic          rx_axis_tlast;
    logic          rx_axis_tready;
    logic          wstart;
    logic          wready;
    logic [31:0]   waddr;
    logic [15:0]   wdata_len;
    logic          wdata_vld;
    logic [DW-1:0] wdata;
    logic [31:0]   frame_cnt;
    logic [31:0]   drop_cnt;
    logic          busy;

    eth_rx_ddr_wr #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(32),
        .LEN_WIDTH (16),
        .BUF_DEPTH (BUF_DEPTH),
        .BASE_ADDR (BASE),
        .RING_SIZE (RING)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_axis_tdata (rx_axis_tdata),
        .rx_axis_tkeep (rx_axis_tkeep),
        .rx_axis_tvalid(rx_axis_tvalid),
        .rx_axis_tlast (rx_axis_tlast),
        .rx_axis_tready(rx_axis_tready),
        .wstart        (wstart),
        .wready        (wready),
        .waddr         (waddr),
        .wdata_len     (wdata_len),
        .wdata_vld     (wdata_vld),
        .wdata         (wdata),
        .frame_cnt     (frame_cnt),
        .drop_cnt      (drop_cnt),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [15:0] len;
        int          nbeats;
    } cmd_t;

    cmd_t        exp_cmd[$];
    logic [63:0] exp_data[$];
    cmd_t        mon_c;
    logic [31:0] ptr_m;
    int          fc_m, dc_m;
    logic [15:0] seq_m;
    int          beats_left;
    longint      next_vld;
    longint      cyc = 0;
    logic        exp_vld;
    int          stall_bad;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares bursts against the scoreboard, sampling on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            beats_left = 0;
        end else begin
            exp_vld = (beats_left > 0) && (cyc >= next_vld);
            if (wdata_vld || exp_vld) begin
                check("wdata_vld", wdata_vld, exp_vld);
                if (wdata_vld && exp_vld) begin
                    check("data_pending", exp_data.size() != 0, 1);
                    if (exp_data.size() != 0)
                        check("wdata", wdata, exp_data.pop_front());
                    beats_left--;
                    next_vld++;
                end
            end
            if (wstart) begin
                check("wstart_wready", wready, 1);
                check("cmd_pending", exp_cmd.size() != 0, 1);
                if (exp_cmd.size() != 0) begin
                    mon_c = exp_cmd.pop_front();
                    check("waddr", waddr, mon_c.addr);
                    check("wdata_len", wdata_len, mon_c.len);
                    beats_left = mon_c.nbeats;
                    next_vld   = cyc + 2;
                end
            end
        end
    end

    task automatic model_reset();
        exp_cmd.delete();
        exp_data.delete();
        ptr_m = BASE;
        fc_m  = 0;
        dc_m  = 0;
        seq_m = '0;
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int t;
        rx_axis_tvalid = 1'b1;
        rx_axis_tdata  = d;
        rx_axis_tkeep  = k;
        rx_axis_tlast  = l;
        t = 0;
        @(negedge clk);
        while (!rx_axis_tready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000)
            check("tready_timeout", rx_axis_tready, 1);
        @(posedge clk);
        #1;
        rx_axis_tvalid = 1'b0;
        rx_axis_tlast  = 1'b0;
    endtask

    // Predicts the outcome of a frame, queues the expected burst, then drives the beats.
    task automatic send_frame(input int n, input logic [7:0] last_keep);
        logic [63:0] words[$];
        int          bytes;
        logic [31:0] adv, start;
        for (int i = 0; i < n; i++)
            words.push_back({$urandom, $urandom});
        bytes = (n - 1) * 8 + $countones(last_keep);
        if (n > BUF_DEPTH || bytes == 0) begin
            dc_m++;
        end else begin
            adv   = 32'((n + HDR) * 8);
            start = (ptr_m + adv > BASE + RING) ? BASE : ptr_m;
            exp_cmd.push_back('{start, 16'(bytes + HDR * 8), n + HDR});
            if (HDR != 0)
                exp_data.push_back(64'({seq_m, 16'(bytes)}));
            foreach (words[i])
                exp_data.push_back(words[i]);
            ptr_m = start + adv;
            fc_m++;
            seq_m = seq_m + 16'd1;
        end
        for (int i = 0; i < n; i++)
            drive_beat(words[i], (i == n - 1) ? last_keep : 8'hFF, i == n - 1);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        rx_axis_tvalid = 1'b0;
        rx_axis_tlast  = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy && !wdata_vld && beats_left == 0 &&
                exp_cmd.size() == 0 && exp_data.size() == 0)
                break;
        end
        check("drain_cmd", exp_cmd.size(), 0);
        check("drain_data", exp_data.size(), 0);
        check("drain_busy", busy, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts();
        check("frame_cnt", frame_cnt, fc_m);
        check("drop_cnt", drop_cnt, dc_m);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tready"}, rx_axis_tready, 0);
        check({tag, "_wstart"}, wstart, 0);
        check({tag, "_wdata_vld"}, wdata_vld, 0);
        check({tag, "_wdata"}, wdata, 0);
        check({tag, "_waddr"}, waddr, BASE);
        check({tag, "_wdata_len"}, wdata_len, 0);
        check({tag, "_frame_cnt"}, frame_cnt, 0);
        check({tag, "_drop_cnt"}, drop_cnt, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rem, n, nv;
        rst            = 1'b1;
        rx_axis_tvalid = 1'b0;
        rx_axis_tdata  = '0;
        rx_axis_tkeep  = '0;
        rx_axis_tlast  = 1'b0;
        wready         = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single 8-beat frame.
        send_frame(8, 8'hFF);
        wait_drain();
        check_counts();

        // Partial last beat, then a one-beat frame at the next aligned slot.
        do_reset();
        send_frame(3, 8'h07);
        send_frame(1, 8'hFF);
        wait_drain();
        check_counts();

        // wready held low: CMD stalls the stream, the queued frame follows intact.
        wready = 1'b0;
        send_frame(4, 8'hFF);
        stall_bad = 0;
        fork
            send_frame(3, 8'h3F);
            begin
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (rx_axis_tready || wstart || !busy)
                        stall_bad++;
                end
                check("cmd_stall", stall_bad, 0);
                @(posedge clk);
                #1;
                wready = 1'b1;
            end
        join
        wait_drain();
        check_counts();

        // Oversize frames (last beat at the limit, and running into DROP), empty frame, then normal.
        send_frame(BUF_DEPTH + 1, 8'hFF);
        send_frame(BUF_DEPTH + 4, 8'hFF);
        send_frame(1, 8'h00);
        send_frame(2, 8'h01);
        wait_drain();
        check_counts();

        // Fill the ring to 4032, then a 16-beat frame must wrap to the base.
        rem = (4032 - int'(ptr_m)) / 8;
        while (rem >= 1 + HDR) begin
            n = (rem - HDR > BUF_DEPTH) ? BUF_DEPTH : rem - HDR;
            send_frame(n, 8'hFF);
            rem = (4032 - int'(ptr_m)) / 8;
        end
        wait_drain();
        send_frame(16, 8'hFF);
        send_frame(1, 8'h0F);
        wait_drain();
        check_counts();

        // Reset in the middle of a burst.
        do_reset();
        send_frame(8, 8'hFF);
        nv = 0;
        for (int i = 0; i < 200 && nv < 3; i++) begin
            @(negedge clk);
            if (wdata_vld)
                nv++;
        end
        check("beats_before_rst", nv, 3);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("mid_rst");
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b0;
        send_frame(5, 8'hFF);
        wait_drain();
        check_counts();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
